// File: rtl/z_buffer_mem.sv
// z_buffer_mem: depth-buffer storage responder for the rasteriser depth test.
// Holds DEPTH = X_RES*Y_RES depth words. After reset, or after a clear
// requested while idle, every word is set to all-ones (maximum depth). Once
// initialised, it serves one read or one write at a time.
//
// Ports:
//   clk_i, rst_i   clock, synchronous active-high reset
//   clear_i        re-initialise the array to all-ones (sampled only when idle)
//   buf_r_w        1 = read request, 0 = write request
//   buf_addr       word address; entry 0 lives at BASE_ADDR
//   buf_data_w     write data
//   buf_data_r     read data, valid while data_r_valid is high
//   data_r_ready   initiator read request / ready to take data
//   data_r_valid   read data valid
//   data_w_valid   write request valid
//   data_w_ready   one-cycle write-accepted pulse
//   init_done_o    array initialised, requests are being serviced
//   addr_err_o     one-cycle pulse for an out-of-range access
module z_buffer_mem #(
  parameter int                   Z_SIZE       = 8,
  parameter int                   X_RES        = 4,
  parameter int                   Y_RES        = 4,
  parameter int                   DEPTH        = X_RES * Y_RES,
  parameter int                   ADDR_SIZE    = 32,
  parameter logic [ADDR_SIZE-1:0] BASE_ADDR    = '0,
  parameter int                   READ_LATENCY = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 clear_i,
  input  logic                 buf_r_w,
  input  logic [ADDR_SIZE-1:0] buf_addr,
  input  logic [Z_SIZE-1:0]    buf_data_w,
  output logic [Z_SIZE-1:0]    buf_data_r,
  input  logic                 data_r_ready,
  output logic                 data_r_valid,
  input  logic                 data_w_valid,
  output logic                 data_w_ready,
  output logic                 init_done_o,
  output logic                 addr_err_o
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  // Wide enough for READ_LATENCY-1 over the whole legal range 1..8.
  localparam int LAT_W = 4;

  typedef enum logic [2:0] {
    S_INIT,
    S_IDLE,
    S_WR_ACK,
    S_RD_WAIT,
    S_RD_RESP
  } state_t;

  state_t            state_reg, state_next;
  logic [IDX_W-1:0]  init_cnt_reg, init_cnt_next;
  logic [LAT_W-1:0]  lat_cnt_reg, lat_cnt_next;
  logic [IDX_W-1:0]  rd_idx_reg, rd_idx_next;
  logic              rd_ok_reg, rd_ok_next;
  logic [Z_SIZE-1:0] data_r_reg, data_r_next;
  logic              r_valid_reg, r_valid_next;
  logic              w_ready_reg, w_ready_next;
  logic              init_done_reg, init_done_next;
  logic              addr_err_reg, addr_err_next;

  logic [Z_SIZE-1:0] mem [DEPTH];
  logic              mem_we;
  logic [IDX_W-1:0]  mem_waddr;
  logic [Z_SIZE-1:0] mem_wdata;

  // Unsigned offset from BASE_ADDR; addresses below the base wrap to huge
  // values and therefore fall out of range as well.
  logic [ADDR_SIZE-1:0] idx;
  logic                 in_range;

  assign idx      = buf_addr - BASE_ADDR;
  assign in_range = (idx < ADDR_SIZE'(DEPTH));

  always_comb begin
    state_next     = state_reg;
    init_cnt_next  = init_cnt_reg;
    lat_cnt_next   = lat_cnt_reg;
    rd_idx_next    = rd_idx_reg;
    rd_ok_next     = rd_ok_reg;
    data_r_next    = data_r_reg;
    r_valid_next   = 1'b0;
    w_ready_next   = 1'b0;
    init_done_next = init_done_reg;
    addr_err_next  = 1'b0;
    mem_we         = 1'b0;
    mem_waddr      = init_cnt_reg;
    mem_wdata      = '1;

    case (state_reg)
      S_INIT: begin
        mem_we = 1'b1;
        if (init_cnt_reg == IDX_W'(DEPTH - 1)) begin
          init_done_next = 1'b1;
          state_next     = S_IDLE;
        end else begin
          init_cnt_next = init_cnt_reg + 1'b1;
        end
      end

      S_IDLE: begin
        if (clear_i) begin
          init_done_next = 1'b0;
          init_cnt_next  = '0;
          state_next     = S_INIT;
        end else if (data_w_valid && !buf_r_w) begin
          // Ready is registered, so it is high exactly while in WR_ACK.
          w_ready_next = 1'b1;
          state_next   = S_WR_ACK;
        end else if (data_r_ready && buf_r_w) begin
          rd_idx_next   = idx[IDX_W-1:0];
          rd_ok_next    = in_range;
          lat_cnt_next  = LAT_W'(READ_LATENCY - 1);
          addr_err_next = !in_range;
          state_next    = S_RD_WAIT;
        end
      end

      S_WR_ACK: begin
        // Commit whatever address/data is present during the ready cycle so
        // an initiator that steps its address on ready stays aligned.
        if (data_w_valid) begin
          if (in_range) begin
            mem_we    = 1'b1;
            mem_waddr = idx[IDX_W-1:0];
            mem_wdata = buf_data_w;
          end else begin
            addr_err_next = 1'b1;
          end
        end
        state_next = S_IDLE;
      end

      S_RD_WAIT: begin
        if (lat_cnt_reg == '0) begin
          data_r_next  = rd_ok_reg ? mem[rd_idx_reg] : '1;
          r_valid_next = 1'b1;
          state_next   = S_RD_RESP;
        end else begin
          lat_cnt_next = lat_cnt_reg - 1'b1;
        end
      end

      S_RD_RESP: begin
        // Either the handshake completes or the initiator has let go; in
        // both cases the response is retired after this cycle.
        r_valid_next = 1'b0;
        state_next   = S_IDLE;
      end

      default: begin
        state_next = S_INIT;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg     <= S_INIT;
      init_cnt_reg  <= '0;
      lat_cnt_reg   <= '0;
      rd_idx_reg    <= '0;
      rd_ok_reg     <= 1'b0;
      data_r_reg    <= '0;
      r_valid_reg   <= 1'b0;
      w_ready_reg   <= 1'b0;
      init_done_reg <= 1'b0;
      addr_err_reg  <= 1'b0;
    end else begin
      state_reg     <= state_next;
      init_cnt_reg  <= init_cnt_next;
      lat_cnt_reg   <= lat_cnt_next;
      rd_idx_reg    <= rd_idx_next;
      rd_ok_reg     <= rd_ok_next;
      data_r_reg    <= data_r_next;
      r_valid_reg   <= r_valid_next;
      w_ready_reg   <= w_ready_next;
      init_done_reg <= init_done_next;
      addr_err_reg  <= addr_err_next;
    end
  end

  // Storage has no reset of its own; INIT fills it after every reset.
  always_ff @(posedge clk_i) begin
    if (mem_we && !rst_i) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  assign buf_data_r   = data_r_reg;
  assign data_r_valid = r_valid_reg;
  assign data_w_ready = w_ready_reg;
  assign init_done_o  = init_done_reg;
  assign addr_err_o   = addr_err_reg;

endmodule

// File: tb/tb_z_buffer_mem.sv
// Directed testbench for z_buffer_mem (X_RES=Y_RES=4, BASE_ADDR=0x100,
// READ_LATENCY=2). One line is printed per comparison.
module tb_z_buffer_mem;

  logic        clk = 1'b0;
  logic        rst;
  logic        clear;
  logic        buf_r_w;
  logic [31:0] buf_addr;
  logic [7:0]  buf_data_w;
  logic [7:0]  buf_data_r;
  logic        data_r_ready;
  logic        data_r_valid;
  logic        data_w_valid;
  logic        data_w_ready;
  logic        init_done;
  logic        addr_err;

  int n_cmp = 0;
  int n_err = 0;
  int err_pulses = 0;

  z_buffer_mem #(
    .Z_SIZE(8), .X_RES(4), .Y_RES(4), .ADDR_SIZE(32),
    .BASE_ADDR(32'h100), .READ_LATENCY(2)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .clear_i(clear),
    .buf_r_w(buf_r_w),
    .buf_addr(buf_addr),
    .buf_data_w(buf_data_w),
    .buf_data_r(buf_data_r),
    .data_r_ready(data_r_ready),
    .data_r_valid(data_r_valid),
    .data_w_valid(data_w_valid),
    .data_w_ready(data_w_ready),
    .init_done_o(init_done),
    .addr_err_o(addr_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (addr_err) err_pulses++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Write request; lat = cycles until ready seen, wide = ready still high
  // after the commit edge.
  task automatic wr(input logic [31:0] a, input logic [7:0] d,
                    output int lat, output logic wide);
    lat  = 99;
    wide = 1'b0;
    buf_r_w      = 1'b0;
    buf_addr     = a;
    buf_data_w   = d;
    data_w_valid = 1'b1;
    for (int n = 1; n <= 10; n++) begin
      tick();
      if (data_w_ready) begin
        lat = n;
        break;
      end
    end
    tick();
    wide = data_w_ready;
    data_w_valid = 1'b0;
  endtask

  // Read request from idle; lat = cycles from the acceptance edge to valid.
  task automatic rd(input logic [31:0] a, output logic [7:0] d, output int lat);
    lat = 99;
    d   = 8'h00;
    buf_r_w      = 1'b1;
    buf_addr     = a;
    data_r_ready = 1'b1;
    tick();
    for (int n = 1; n <= 12; n++) begin
      tick();
      if (data_r_valid) begin
        lat = n;
        d   = buf_data_r;
        break;
      end
    end
    tick();
    data_r_ready = 1'b0;
  endtask

  task automatic wait_init(output int n_cyc, output int busy_seen);
    n_cyc     = 999;
    busy_seen = 0;
    for (int n = 1; n <= 40; n++) begin
      tick();
      if (data_r_valid || data_w_ready) busy_seen++;
      if (init_done) begin
        n_cyc = n;
        break;
      end
    end
  endtask

  initial begin
    int          lat;
    int          cyc;
    int          busy;
    int          e0;
    int          pulses;
    int          bad_gap;
    int          last_pulse;
    logic        wide;
    logic        pending;
    logic [7:0]  d;

    rst = 1'b1; clear = 1'b0; buf_r_w = 1'b0; buf_addr = 32'h100;
    buf_data_w = 8'h00; data_r_ready = 1'b0; data_w_valid = 1'b0;
    repeat (3) tick();

    check("rst_data_r", 32'(buf_data_r), 32'h0);
    check("rst_r_valid", 32'(data_r_valid), 32'h0);
    check("rst_w_ready", 32'(data_w_ready), 32'h0);
    check("rst_init_done", 32'(init_done), 32'h0);
    check("rst_addr_err", 32'(addr_err), 32'h0);

    rst = 1'b0;
    wait_init(cyc, busy);
    check("init_cycles", 32'(cyc), 32'd16);
    check("init_quiet", 32'(busy), 32'd0);
    rd(32'h10F, d, lat);
    check("rd_10F_init", 32'(d), 32'hFF);
    check("rd_10F_lat", 32'(lat), 32'd2);

    // Basic write then read-back.
    wr(32'h105, 8'h3C, lat, wide);
    check("wr_105_lat", 32'(lat), 32'd1);
    check("wr_105_pulse_width", 32'(wide), 32'h0);
    rd(32'h105, d, lat);
    check("rd_105_data", 32'(d), 32'h3C);
    check("rd_105_lat", 32'(lat), 32'd2);

    // Flush: valid held, address stepped after each accepted write.
    pulses = 0; bad_gap = 0; last_pulse = -1; pending = 1'b0;
    buf_r_w = 1'b0; buf_addr = 32'h100; buf_data_w = 8'hFF; data_w_valid = 1'b1;
    for (int c = 0; c < 80; c++) begin
      tick();
      if (pending) begin
        pending = 1'b0;
        if (pulses == 16) begin
          data_w_valid = 1'b0;
          break;
        end
        buf_addr = buf_addr + 32'd1;
      end
      if (data_w_ready) begin
        if (last_pulse >= 0 && c - last_pulse != 2) bad_gap++;
        last_pulse = c;
        pulses++;
        pending = 1'b1;
      end
    end
    data_w_valid = 1'b0;
    check("flush_pulses", 32'(pulses), 32'd16);
    check("flush_gaps", 32'(bad_gap), 32'd0);
    for (int i = 0; i < 16; i++) begin
      rd(32'h100 + 32'(i), d, lat);
      check($sformatf("flush_rd_%0h", 32'h100 + 32'(i)), 32'(d), 32'hFF);
    end

    // Out-of-range write (would alias entry 0) and read (would alias entry 15).
    wr(32'h10F, 8'h77, lat, wide);
    e0 = err_pulses;
    wr(32'h110, 8'h55, lat, wide);
    tick();
    check("oor_wr_ready", 32'(lat), 32'd1);
    check("oor_wr_err", 32'(err_pulses - e0), 32'd1);
    e0 = err_pulses;
    rd(32'h0FF, d, lat);
    check("oor_rd_data", 32'(d), 32'hFF);
    check("oor_rd_err", 32'(err_pulses - e0), 32'd1);
    rd(32'h100, d, lat);
    check("oor_entry0_kept", 32'(d), 32'hFF);
    rd(32'h10F, d, lat);
    check("entry15_data", 32'(d), 32'h77);

    // Initiator abandons a read before data arrives.
    buf_r_w = 1'b1; buf_addr = 32'h10F; data_r_ready = 1'b1;
    tick();
    data_r_ready = 1'b0;
    cyc = 99;
    for (int n = 1; n <= 12; n++) begin
      tick();
      if (data_r_valid) begin
        cyc = n;
        break;
      end
    end
    check("abandon_valid_lat", 32'(cyc), 32'd2);
    tick();
    check("abandon_valid_drop", 32'(data_r_valid), 32'h0);
    wr(32'h103, 8'h21, lat, wide);
    check("abandon_next_wr", 32'(lat), 32'd1);
    rd(32'h103, d, lat);
    check("abandon_rd_103", 32'(d), 32'h21);

    // Clear while idle re-initialises the array.
    wr(32'h101, 8'h12, lat, wide);
    rd(32'h101, d, lat);
    check("pre_clear_101", 32'(d), 32'h12);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("clear_init_low", 32'(init_done), 32'h0);
    wait_init(cyc, busy);
    check("clear_init_cycles", 32'(cyc), 32'd16);
    rd(32'h101, d, lat);
    check("post_clear_101", 32'(d), 32'hFF);

    // Reset during RD_WAIT discards the read and restarts INIT.
    wr(32'h102, 8'h44, lat, wide);
    buf_r_w = 1'b1; buf_addr = 32'h102; data_r_ready = 1'b1;
    tick();
    rst = 1'b1;
    tick();
    check("rst_mid_r_valid", 32'(data_r_valid), 32'h0);
    check("rst_mid_init_done", 32'(init_done), 32'h0);
    rst = 1'b0;
    data_r_ready = 1'b0;
    wait_init(cyc, busy);
    check("rst_mid_init_cycles", 32'(cyc), 32'd16);
    check("rst_mid_no_resp", 32'(busy), 32'd0);
    rd(32'h102, d, lat);
    check("rst_mid_rd_102", 32'(d), 32'hFF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
